// File: rtl/obstacle_scroller_pkg.sv
// Shared types and constants for the obstacle scroller engine.
package obstacle_scroller_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned WL_W    = 2;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned TIPO_W  = 4;
    localparam int unsigned LFSR_W  = 8;

    localparam logic [WL_W-1:0] WL_NONE = 2'b00;
    localparam logic [WL_W-1:0] WL_WIN  = 2'b01;
    localparam logic [WL_W-1:0] WL_LOSE = 2'b10;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_WIN,
        ST_LOSE
    } state_t;

    // Maximal-length 8-bit Fibonacci LFSR, taps 8,6,5,4; a nonzero seed never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/obstacle_scroller_if.sv
// Game-side bus of the obstacle scroller: control in, ROM/hero in, lane and status out.
interface obstacle_scroller_if #(
    parameter int unsigned N_POS = 3
);
    import obstacle_scroller_pkg::*;

    logic                     start;
    logic                     abort;
    logic [SEG_W-1:0]         heroe;
    logic [SEG_W-1:0]         obstaculo;
    logic [TIPO_W-1:0]        tipo_obs;
    logic [SEG_W*N_POS-1:0]   display_obs;
    logic                     clk_obstaculos;
    logic [WL_W-1:0]          W_or_L;
    logic [SCORE_W-1:0]       score;
    logic                     busy;

    modport master (
        output start, abort, heroe, obstaculo,
        input  tipo_obs, display_obs, clk_obstaculos, W_or_L, score, busy
    );

    modport slave (
        input  start, abort, heroe, obstaculo,
        output tipo_obs, display_obs, clk_obstaculos, W_or_L, score, busy
    );

endinterface

// File: rtl/obstacle_scroller_scroll_tick_gen.sv
// Scroll period counter with clamped speed-up; flags the wrap cycle and emits a registered tick.
module scroll_tick_gen #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned MIN_DIV    = 5_000_000,
    parameter int unsigned SPEED_STEP = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    input  logic speed_up,
    output logic wrap_c,
    output logic tick
);

    localparam int unsigned CNT_W    = $clog2(TICK_DIV + 1);
    localparam int unsigned CLAMP_AT = MIN_DIV + SPEED_STEP;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;

    // >= rather than == so a shortened period never lets the counter run past its new end.
    assign wrap_c = run && !clear && (cnt_q >= period_q - CNT_W'(1));

    // Compare before subtracting so the period cannot underflow below MIN_DIV.
    always_comb begin
        period_d = period_q;
        if (32'(period_q) >= CLAMP_AT) begin
            period_d = period_q - CNT_W'(SPEED_STEP);
        end else begin
            period_d = CNT_W'(MIN_DIV);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= CNT_W'(TICK_DIV);
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                cnt_q    <= '0;
                period_q <= CNT_W'(TICK_DIV);
            end else begin
                if (speed_up) begin
                    period_q <= period_d;
                end
                if (wrap_c) begin
                    cnt_q <= '0;
                    tick  <= 1'b1;
                end else if (run) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Obstacle lane engine: scrolls ROM obstacles toward the hero, scores passes, detects hits,
// speeds up and declares win/loss.
module obstacle_scroller
    import obstacle_scroller_pkg::*;
#(
    parameter int unsigned N_POS       = 3,
    parameter int unsigned TICK_DIV    = 25_000_000,
    parameter int unsigned MIN_DIV     = 5_000_000,
    parameter int unsigned SPEED_STEP  = 2_000_000,
    parameter int unsigned SPEED_EVERY = 4,
    parameter int unsigned WIN_COUNT   = 16,
    parameter int unsigned MIN_GAP     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_scroller_if.slave   bus
);

    localparam int unsigned GAP_W = $clog2(MIN_GAP + 2);

    state_t                         state_q;
    state_t                         state_d;
    logic [N_POS-1:0][SEG_W-1:0]    lane_q;
    logic [SCORE_W-1:0]             score_q;
    logic [WL_W-1:0]                wl_q;
    logic                           busy_q;
    logic [LFSR_W-1:0]              lfsr_q;
    logic [TIPO_W-1:0]              tipo_q;
    logic [GAP_W-1:0]               gap_q;

    logic                           wrap_c;
    logic                           tick_q;
    logic                           clear_c;
    logic                           tick_ok_c;
    logic                           speed_up_c;
    logic                           hit_c;
    logic                           pass_c;
    logic                           win_c;
    logic                           insert_c;
    logic [SCORE_W-1:0]             score_inc_c;

    scroll_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .MIN_DIV    (MIN_DIV),
        .SPEED_STEP (SPEED_STEP)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state_q == ST_PLAY),
        .clear    (clear_c),
        .speed_up (speed_up_c),
        .wrap_c   (wrap_c),
        .tick     (tick_q)
    );

    // Tick decisions all look at the lane as it stands before the scroll.
    assign hit_c       = |(lane_q[0] & bus.heroe);
    assign pass_c      = |lane_q[0];
    assign score_inc_c = score_q + SCORE_W'(1);
    assign win_c       = pass_c && (score_inc_c == SCORE_W'(WIN_COUNT));
    assign insert_c    = lfsr_q[0] && (gap_q >= GAP_W'(MIN_GAP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort beats start; start restarts from any state; a hit outranks a win.
    always_comb begin
        state_d    = state_q;
        clear_c    = 1'b0;
        tick_ok_c  = 1'b0;
        speed_up_c = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            clear_c = 1'b1;
        end else if (bus.start) begin
            state_d = ST_PLAY;
            clear_c = 1'b1;
        end else if (wrap_c) begin
            tick_ok_c = 1'b1;
            if (hit_c) begin
                state_d = ST_LOSE;
            end else begin
                speed_up_c = pass_c && ((32'(score_inc_c) % SPEED_EVERY) == 32'd0);
                if (win_c) begin
                    state_d = ST_WIN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            score_q <= '0;
            wl_q    <= WL_NONE;
            busy_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            tipo_q  <= '0;
            gap_q   <= GAP_W'(MIN_GAP);
        end else begin
            busy_q <= (state_d == ST_PLAY);
            if (clear_c) begin
                lane_q  <= '0;
                score_q <= '0;
                wl_q    <= WL_NONE;
                gap_q   <= GAP_W'(MIN_GAP);
            end else if (tick_ok_c) begin
                lfsr_q <= lfsr_next(lfsr_q);
                tipo_q <= lfsr_q[LFSR_W-1:LFSR_W-TIPO_W];
                if (hit_c) begin
                    wl_q <= WL_LOSE;
                end else begin
                    if (pass_c) begin
                        score_q <= score_inc_c;
                    end
                    if (win_c) begin
                        wl_q <= WL_WIN;
                    end else begin
                        for (int i = 0; i < int'(N_POS) - 1; i++) begin
                            lane_q[i] <= lane_q[i+1];
                        end
                        lane_q[N_POS-1] <= insert_c ? bus.obstaculo : '0;
                        if (insert_c) begin
                            gap_q <= '0;
                        end else if (gap_q < GAP_W'(MIN_GAP)) begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.display_obs    = lane_q;
    assign bus.tipo_obs       = tipo_q;
    assign bus.clk_obstaculos = tick_q;
    assign bus.W_or_L         = wl_q;
    assign bus.score          = score_q;
    assign bus.busy           = busy_q;

endmodule
